// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and constants for the systolic array sequencer.
// Holds the FSM state encoding, per-lane skew depth and drain length.
package systolic_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        ALIGN,
        DRAIN,
        FIN
    } seq_state_t;

    // ALIGN lasts for the buffer read latency plus the first skew stage.
    localparam int ALIGN_LEN = 2;

    function automatic int skew_depth(input int lane);
        return lane + 1;
    endfunction

    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/skew_line.sv
// Per-lane delay chain feeding one edge of the array.
// The first stage loads zero whenever the incoming buffer data is not valid.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         sys_rst_n,
    input  logic         load_en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= load_en ? din : '0;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary MAC array: reads operand columns/rows,
// skews them onto the array edges and drives the corner cal_en/cal_done pair.
module systolic_seq_ctrl
    import systolic_seq_ctrl_pkg::*;
#(
    parameter int N      = 3,
    parameter int IN_LEN = 8,
    parameter int K_W    = 8
) (
    input  logic                clk,
    input  logic                sys_rst_n,
    input  logic                start,
    input  logic [K_W-1:0]      k_len,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [K_W-1:0]      rd_addr,
    input  logic [N*IN_LEN-1:0] a_rd_data,
    input  logic [N*IN_LEN-1:0] b_rd_data,
    output logic [N*IN_LEN-1:0] west_bus,
    output logic [N*IN_LEN-1:0] north_bus,
    output logic                cal_en,
    output logic                cal_done
);

    localparam logic [K_W-1:0] ALIGN_LAST = K_W'(ALIGN_LEN - 1);
    localparam logic [K_W-1:0] DRAIN_LAST = K_W'(drain_len(N) - 1);

    seq_state_t     state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic [K_W-1:0] step_q, step_d;
    logic [K_W-1:0] cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           rd_en_q;
    logic           cal_en_q, cal_done_q;
    logic           cal_done_d;
    logic           rd_en_c, done_c;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            step_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            cal_en_q   <= 1'b0;
            cal_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            rd_en_q    <= rd_en_c;
            // cal_en spans the valid skewed data plus the closing cal_done cycle
            cal_en_q   <= rd_en_q | cal_done_d;
            cal_done_q <= cal_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        rd_en_c    = 1'b0;
        done_c     = 1'b0;
        cal_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                step_d = '0;
                if (start) begin
                    k_d = k_len;
                    if (k_len == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = FEED;
                        busy_d  = 1'b1;
                    end
                end
            end
            FEED: begin
                rd_en_c = 1'b1;
                if (step_q == k_q - K_W'(1)) begin
                    state_d = ALIGN;
                    step_d  = '0;
                    cnt_d   = ALIGN_LAST;
                end else begin
                    step_d = step_q + K_W'(1);
                end
            end
            ALIGN: begin
                if (cnt_q == '0) begin
                    cal_done_d = 1'b1;
                    state_d    = DRAIN;
                    cnt_d      = DRAIN_LAST;
                end else begin
                    cnt_d = cnt_q - K_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q - K_W'(1);
                end
            end
            FIN: begin
                done_c  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_c;
    assign rd_en    = rd_en_c;
    assign rd_addr  = step_q;
    assign cal_en   = cal_en_q;
    assign cal_done = cal_done_q;

    // Lane i gets i+1 register stages so the operand wavefront enters diagonally.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(
            .DEPTH(skew_depth(i)),
            .W    (IN_LEN)
        ) u_a_skew (
            .clk      (clk),
            .sys_rst_n(sys_rst_n),
            .load_en  (rd_en_q),
            .din      (a_rd_data[i*IN_LEN +: IN_LEN]),
            .dout     (west_bus[i*IN_LEN +: IN_LEN])
        );

        skew_line #(
            .DEPTH(skew_depth(i)),
            .W    (IN_LEN)
        ) u_b_skew (
            .clk      (clk),
            .sys_rst_n(sys_rst_n),
            .load_en  (rd_en_q),
            .din      (b_rd_data[i*IN_LEN +: IN_LEN]),
            .dout     (north_bus[i*IN_LEN +: IN_LEN])
        );
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: job-level timing model checked every cycle,
// an emulated PE array fed from the edge buses, and hand-computed pins.
module tb_systolic_seq_ctrl;

    localparam int N       = 3;
    localparam int IN_LEN  = 8;
    localparam int K_W     = 8;
    localparam int HIST    = 300;

    logic                clk;
    logic                sys_rst_n;
    logic                start;
    logic [K_W-1:0]      k_len;
    logic                busy;
    logic                done;
    logic                rd_en;
    logic [K_W-1:0]      rd_addr;
    logic [N*IN_LEN-1:0] a_rd_data;
    logic [N*IN_LEN-1:0] b_rd_data;
    logic [N*IN_LEN-1:0] west_bus;
    logic [N*IN_LEN-1:0] north_bus;
    logic                cal_en;
    logic                cal_done;

    systolic_seq_ctrl #(.N(N), .IN_LEN(IN_LEN), .K_W(K_W)) dut (
        .clk      (clk),
        .sys_rst_n(sys_rst_n),
        .start    (start),
        .k_len    (k_len),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .a_rd_data(a_rd_data),
        .b_rd_data(b_rd_data),
        .west_bus (west_bus),
        .north_bus(north_bus),
        .cal_en   (cal_en),
        .cal_done (cal_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // operand buffers: a_mem[i][k] = A[i][k], b_mem[j][k] = B[k][j]
    logic [IN_LEN-1:0] a_mem [N][256];
    logic [IN_LEN-1:0] b_mem [N][256];

    // job model state
    int  cyc = 0;
    bit  job_valid = 0;
    int  job_s, job_k, job_end;
    int  done_total = 0;

    // per-job observation log
    int log_rd_first, log_rd_cnt, log_addr_max;
    int log_cal_first, log_cal_last, log_cal_cnt, log_caldone_d, log_caldone_cnt;
    int log_done_d, log_busy_first, log_busy_cnt;

    logic [N*IN_LEN-1:0] w_hist [HIST];
    logic [N*IN_LEN-1:0] n_hist [HIST];
    logic                cal_hist [HIST];
    logic [31:0]         c_arr [N][N];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp_v, $time);
        end
    endtask

    // emulated synchronous-read operand buffers, garbage when not read
    logic           mem_en;
    logic [K_W-1:0] mem_addr;
    always @(posedge clk) begin
        mem_en   = rd_en;
        mem_addr = rd_addr;
        #1;
        for (int i = 0; i < N; i++) begin
            a_rd_data[i*IN_LEN +: IN_LEN] = mem_en ? a_mem[i][mem_addr] : IN_LEN'($urandom);
            b_rd_data[i*IN_LEN +: IN_LEN] = mem_en ? b_mem[i][mem_addr] : IN_LEN'($urandom);
        end
    end

    // per-cycle compare against the job-level timing model
    int                  d;
    logic                e_rd_en, e_cal_en, e_cal_done, e_done, e_busy;
    logic [K_W-1:0]      e_addr;
    logic [N*IN_LEN-1:0] e_west, e_north;
    always @(negedge clk) begin
        cyc++;
        e_rd_en = 0; e_cal_en = 0; e_cal_done = 0; e_done = 0; e_busy = 0;
        e_addr = '0; e_west = '0; e_north = '0;
        if (sys_rst_n && job_valid) begin
            d = cyc - job_s;
            if (job_k == 0) begin
                e_done = (d == 1);
            end else begin
                e_rd_en    = (d >= 1 && d <= job_k);
                e_addr     = e_rd_en ? K_W'(d - 1) : '0;
                e_cal_en   = (d >= 3 && d <= job_k + 3);
                e_cal_done = (d == job_k + 3);
                e_done     = (d == job_k + 8);
                e_busy     = (d >= 1 && d <= job_k + 8);
                for (int i = 0; i < N; i++) begin
                    if (d - 3 - i >= 0 && d - 3 - i < job_k) begin
                        e_west[i*IN_LEN +: IN_LEN]  = a_mem[i][d-3-i];
                        e_north[i*IN_LEN +: IN_LEN] = b_mem[i][d-3-i];
                    end
                end
            end
        end
        checkOutput("rd_en", 32'(rd_en), 32'(e_rd_en));
        checkOutput("rd_addr", 32'(rd_addr), 32'(e_addr));
        checkOutput("cal_en", 32'(cal_en), 32'(e_cal_en));
        checkOutput("cal_done", 32'(cal_done), 32'(e_cal_done));
        checkOutput("done", 32'(done), 32'(e_done));
        checkOutput("busy", 32'(busy), 32'(e_busy));
        checkOutput("west_bus", 32'(west_bus), 32'(e_west));
        checkOutput("north_bus", 32'(north_bus), 32'(e_north));

        if (!sys_rst_n) begin
            job_valid = 0;
        end else if (start && (!job_valid || cyc > job_end)) begin
            job_valid = 1;
            job_s     = cyc;
            job_k     = int'(k_len);
            job_end   = (job_k == 0) ? cyc + 1 : cyc + job_k + 8;
            log_rd_first = -1; log_rd_cnt = 0; log_addr_max = 0;
            log_cal_first = -1; log_cal_last = -1; log_cal_cnt = 0;
            log_caldone_d = -1; log_caldone_cnt = 0;
            log_done_d = -1; log_busy_first = -1; log_busy_cnt = 0;
            for (int t = 0; t < HIST; t++) begin
                w_hist[t] = '0; n_hist[t] = '0; cal_hist[t] = 0;
            end
        end

        if (sys_rst_n && job_valid) begin
            d = cyc - job_s;
            if (rd_en) begin
                if (log_rd_first < 0) log_rd_first = d;
                log_rd_cnt++;
                if (int'(rd_addr) > log_addr_max) log_addr_max = int'(rd_addr);
            end
            if (cal_en) begin
                if (log_cal_first < 0) log_cal_first = d;
                log_cal_last = d;
                log_cal_cnt++;
            end
            if (cal_done) begin
                log_caldone_d = d;
                log_caldone_cnt++;
            end
            if (done && log_done_d < 0) log_done_d = d;
            if (busy) begin
                if (log_busy_first < 0) log_busy_first = d;
                log_busy_cnt++;
            end
            if (d >= 0 && d < HIST) begin
                w_hist[d]   = west_bus;
                n_hist[d]   = north_bus;
                cal_hist[d] = cal_en;
            end
        end
        if (done) done_total++;
    end

    task automatic applyStimulus(input int k);
        @(posedge clk);
        #1;
        start = 1'b1;
        k_len = K_W'(k);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        if (!done) checkOutput("done_timeout", 32'(done), 32'd1);
        #1;
    endtask

    // PE(i,j) sees west lane i delayed j, north lane j delayed i, cal_en delayed i+j
    task automatic checkArray(input int k);
        logic [31:0] acc, ref_v;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int tau = 0; tau <= k + 3 && tau + N < HIST; tau++) begin
                    if (cal_hist[tau])
                        acc += 32'(w_hist[tau+i][i*IN_LEN +: IN_LEN]) *
                               32'(n_hist[tau+j][j*IN_LEN +: IN_LEN]);
                end
                ref_v = 0;
                for (int kk = 0; kk < k; kk++)
                    ref_v += 32'(a_mem[i][kk]) * 32'(b_mem[j][kk]);
                c_arr[i][j] = acc;
                checkOutput($sformatf("C[%0d][%0d]", i, j), acc, ref_v);
            end
        end
    endtask

    task automatic loadIdentity();
        for (int i = 0; i < N; i++) begin
            for (int kk = 0; kk < 256; kk++) begin
                a_mem[i][kk] = (i == kk) ? 8'd1 : 8'd0;
                b_mem[i][kk] = (i == kk) ? 8'd1 : 8'd0;
            end
        end
    endtask

    task automatic checkNominalK4();
        checkOutput("k4_rd_first", 32'(log_rd_first), 32'd1);
        checkOutput("k4_rd_cnt", 32'(log_rd_cnt), 32'd4);
        checkOutput("k4_addr_max", 32'(log_addr_max), 32'd3);
        checkOutput("k4_cal_first", 32'(log_cal_first), 32'd3);
        checkOutput("k4_cal_last", 32'(log_cal_last), 32'd7);
        checkOutput("k4_caldone_d", 32'(log_caldone_d), 32'd7);
        checkOutput("k4_caldone_cnt", 32'(log_caldone_cnt), 32'd1);
        checkOutput("k4_done_d", 32'(log_done_d), 32'd12);
        checkOutput("k4_busy_first", 32'(log_busy_first), 32'd1);
        checkOutput("k4_busy_cnt", 32'(log_busy_cnt), 32'd12);
    endtask

    int first_s;
    int done_snap;

    initial begin
        sys_rst_n = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        for (int i = 0; i < N; i++)
            for (int kk = 0; kk < 256; kk++) begin
                a_mem[i][kk] = '0;
                b_mem[i][kk] = '0;
            end
        #12;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_west", 32'(west_bus), 32'd0);
        repeat (3) @(posedge clk);
        #2 sys_rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] K=4 identity");
        loadIdentity();
        applyStimulus(4);
        waitDone(400);
        checkNominalK4();
        checkArray(4);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                checkOutput($sformatf("ident_C[%0d][%0d]", i, j), c_arr[i][j], (i == j) ? 32'd1 : 32'd0);
        repeat (3) @(posedge clk);

        $display("[TB] K=1 lane values");
        for (int i = 0; i < N; i++) begin
            a_mem[i][0] = IN_LEN'(2 + i);
            b_mem[i][0] = IN_LEN'(5 + i);
        end
        applyStimulus(1);
        waitDone(400);
        checkOutput("k1_west2_s4", 32'(w_hist[4][2*IN_LEN +: IN_LEN]), 32'd0);
        checkOutput("k1_west2_s5", 32'(w_hist[5][2*IN_LEN +: IN_LEN]), 32'd4);
        checkOutput("k1_west2_s6", 32'(w_hist[6][2*IN_LEN +: IN_LEN]), 32'd0);
        checkOutput("k1_cal_first", 32'(log_cal_first), 32'd3);
        checkOutput("k1_cal_last", 32'(log_cal_last), 32'd4);
        checkOutput("k1_done_d", 32'(log_done_d), 32'd9);
        checkArray(1);
        checkOutput("k1_C22", c_arr[2][2], 32'd28);
        repeat (3) @(posedge clk);

        $display("[TB] K=0");
        applyStimulus(0);
        waitDone(50);
        checkOutput("k0_done_d", 32'(log_done_d), 32'd1);
        checkOutput("k0_busy_cnt", 32'(log_busy_cnt), 32'd0);
        checkOutput("k0_rd_cnt", 32'(log_rd_cnt), 32'd0);
        checkOutput("k0_cal_cnt", 32'(log_cal_cnt), 32'd0);
        repeat (3) @(posedge clk);

        $display("[TB] restart ignored, start held across FIN");
        loadIdentity();
        applyStimulus(4);
        first_s = job_s;
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        waitDone(400);
        checkNominalK4();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 start = 1'b0;
        checkOutput("held_start_s", 32'(job_s - first_s), 32'd13);
        waitDone(400);
        checkNominalK4();
        repeat (3) @(posedge clk);

        $display("[TB] reset mid-job");
        applyStimulus(4);
        done_snap = done_total;
        repeat (5) @(posedge clk);
        #2 sys_rst_n = 1'b0;
        #1;
        checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
        checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("rst_cal_en", 32'(cal_en), 32'd0);
        checkOutput("rst_cal_done", 32'(cal_done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_west", 32'(west_bus), 32'd0);
        checkOutput("rst_north", 32'(north_bus), 32'd0);
        repeat (3) @(posedge clk);
        #2 sys_rst_n = 1'b1;
        repeat (15) @(posedge clk);
        checkOutput("rst_no_done", 32'(done_total - done_snap), 32'd0);
        applyStimulus(4);
        waitDone(400);
        checkNominalK4();
        checkArray(4);
        repeat (3) @(posedge clk);

        $display("[TB] K=255 random");
        for (int i = 0; i < N; i++)
            for (int kk = 0; kk < 256; kk++) begin
                a_mem[i][kk] = IN_LEN'($urandom);
                b_mem[i][kk] = IN_LEN'($urandom);
            end
        applyStimulus(255);
        waitDone(600);
        checkOutput("k255_addr_max", 32'(log_addr_max), 32'd254);
        checkOutput("k255_rd_cnt", 32'(log_rd_cnt), 32'd255);
        checkOutput("k255_done_d", 32'(log_done_d), 32'd263);
        checkArray(255);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for an N x N output-stationary MAC array computing C = A x B with runtime inner dimension k_len.
- Reads one A column and one B row per step from two banked operand buffers, each N lanes wide, and applies the diagonal skew on the feed path.
- Drives the corner cal_en/cal_done pair into the array; the PEs propagate both one hop per cycle.
- Signals completion once the last PE's dout is valid.

Parameters:
- N, 3, array dimension (rows = cols = N).
- IN_LEN, 8, operand lane width.
- K_W, 8, width of k_len and of the buffer address.

Ports:
- clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- k_len  in  K_W  inner dimension K; captured on start accept
- busy  out  1  high from the cycle after start accept through the done cycle
- done  out  1  one-cycle completion pulse
- rd_en  out  1  operand buffer read strobe (A and B read together)
- rd_addr  out  K_W  step index k
- a_rd_data  in  N*IN_LEN  A[i][k] on lane i; 1-cycle read latency
- b_rd_data  in  N*IN_LEN  B[k][j] on lane j; 1-cycle read latency
- west_bus  out  N*IN_LEN  lane i drives westin of PE(i,0)
- north_bus  out  N*IN_LEN  lane j drives northin of PE(0,j)
- cal_en  out  1  to PE(0,0)
- cal_done  out  1  to PE(0,0)

Behaviour:
- Reset: asynchronous, active-low. All outputs, skew registers, counters and state clear to 0; state goes to IDLE.
- Reset asserted mid-operation aborts immediately. No done pulse is produced.
- Let s be the cycle in which start=1 is sampled in IDLE.
  - k_len is latched as K.
  - Start is ignored outside IDLE.
- FSM states: IDLE, FEED, ALIGN, DRAIN, FIN.
- IDLE -> FEED on start with K > 0.
  - With K == 0: go to FIN. done pulses at s+1; rd_en and cal_en never assert.
- FEED: rd_en=1 with rd_addr = 0..K-1 in cycles s+1..s+K.
  - Exit to ALIGN after addr K-1.
  - rd_addr returns to 0 whenever rd_en=0.
- Skew path:
  - Lane i of a_rd_data and b_rd_data passes through i+1 registers before reaching west_bus/north_bus lane i.
  - Skew registers load 0 whenever the buffer data is not valid (the cycle after a cycle with rd_en=0). Lanes are therefore exactly 0 outside their K-cycle window.
- Timing reference: t0 = s+3 is the first cycle where west lane 0 = A[0][0].
  - cal_en is registered high for cycles t0..t0+K (K+1 cycles).
  - cal_done is high only in t0+K, coincident with cal_en.
- ALIGN covers the cal_en tail; DRAIN then waits out the array's wavefront. A down-counter loaded at entry to each state handles both.
- Completion:
  - PE(i,j) dout is valid in cycle t0+K+i+j+1.
  - done pulses in t0+K+2N-1, i.e. the cycle the last PE's dout is valid. FSM is in FIN.
  - busy falls in the cycle after done.
  - FIN -> IDLE unconditionally.
  - start held high across FIN is accepted as a new job on the first IDLE cycle.
- Arithmetic: step and drain counters are K_W bits and never wrap, since K <= 2^K_W - 1.
- No back-pressure: the result collector must absorb douts at the stated cycles.

Decomposition:
- Shared package:
  - FSM state enum.
  - Skew-depth function (lane index + 1).
  - Drain constant 2N-1.
- One sub-module: skew_line (per-lane delay chain of parameterised depth with synchronous zero-load). Instantiated 2N times via generate.

Test Plan:
- N=3, K=4, A = B = identity padded with 0:
  - rd_en high s+1..s+4; cal_en high s+3..s+7; cal_done at s+7 only.
  - done at s+12; busy high s+1..s+12.
  - Array douts equal the identity.
- N=3, K=1, a_rd_data = 2/3/4 per lane, b_rd_data = 5/6/7 per lane:
  - west lane 2 carries 4 only in cycle s+5.
  - cal_en high s+3..s+4; done at s+9.
  - PE(2,2) dout = 28.
- K=0: done at s+1; busy low throughout; rd_en and cal_en never assert.
- start pulsed again at s+5 during the K=4 job: ignored, with identical waveform to the first test. A start held through FIN starts a second job beginning in IDLE at s+13.
- sys_rst_n low at s+6:
  - All outputs 0 asynchronously; no done.
  - Next start after release gives the nominal timing.
- N=3, K=255, random 8-bit operands:
  - rd_addr reaches 254 without wrap; done at s+3+255+5.
  - Captured douts match the reference product truncated to OUT_LEN.
